// File: rtl/serdes_pkg.sv
// Shared definitions for the serial link stages (serialiser and deserialiser).
package serdes_pkg;

  // Default word width, common to the parallel-to-serial and serial-to-parallel stages.
  localparam int SERDES_N = 4;

  // Receiver frame state.
  typedef enum logic {
    S_IDLE     = 1'b0,
    S_ASSEMBLE = 1'b1
  } state_t;

endpackage

// File: rtl/sipo_shift_reg.sv
// N-bit right-shift register: new bits enter at the MSB, so after N shifts the
// first bit received sits at index 0. The combinational next value is exported
// so the owner can capture a completed word on the same edge as its last bit.
module sipo_shift_reg #(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic         clr,
  input  logic         din,
  output logic [N-1:0] q_next
);

  logic [N-1:0] q_reg;

  // Next value: shift when enabled (clr drops the older bits), else hold or clear.
  always_comb begin
    q_next = q_reg;
    if (en) begin
      q_next = clr ? {din, {(N-1){1'b0}}} : {din, q_reg[N-1:1]};
    end else if (clr) begin
      q_next = '0;
    end
  end

  // Register update with asynchronous reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_reg <= '0;
    end else begin
      q_reg <= q_next;
    end
  end

endmodule

// File: rtl/serial_to_parallel_rx.sv
// Deserialiser: rebuilds N-bit words from an LSB-first serial stream framed by
// SOF, and hands them to a consumer through a valid/ready holding register.
// Sticky flags report dropped words (OVERRUN) and aborted partial words (FRAME_ERR).
module serial_to_parallel_rx
  import serdes_pkg::*;
#(
  parameter int N = SERDES_N
) (
  input  logic         CLK,
  input  logic         n_Reset,
  input  logic         EN,
  input  logic         SERIAL_IN,
  input  logic         SOF,
  input  logic         READY,
  input  logic         CLR_ERR,
  output logic [N-1:0] DATAR,
  output logic         VALID,
  output logic         OVERRUN,
  output logic         FRAME_ERR
);

  localparam int CNT_W = $clog2(N);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(N - 1);

  state_t           state_reg, state_next;
  logic [CNT_W-1:0] count_reg, count_next;
  logic [N-1:0]     datar_reg;
  logic             valid_reg;
  logic             overrun_reg;
  logic             frame_err_reg;

  logic             shift_en;
  logic             shift_clr;
  logic             word_done;
  logic             frame_abort;
  logic             hold_free;
  logic [N-1:0]     shift_next;

  sipo_shift_reg #(
    .N(N)
  ) u_shift (
    .clk    (CLK),
    .rst_n  (n_Reset),
    .en     (shift_en),
    .clr    (shift_clr),
    .din    (SERIAL_IN),
    .q_next (shift_next)
  );

  // The holding register can take a new word if it is empty or drained this cycle.
  assign hold_free = !valid_reg || READY;

  // Frame FSM: next state, bit counter and shift-register control.
  always_comb begin
    state_next  = state_reg;
    count_next  = count_reg;
    shift_en    = 1'b0;
    shift_clr   = 1'b0;
    word_done   = 1'b0;
    frame_abort = 1'b0;
    case (state_reg)
      S_IDLE: begin
        if (EN && SOF) begin
          shift_en   = 1'b1;
          shift_clr  = 1'b1;
          count_next = CNT_W'(1);
          state_next = S_ASSEMBLE;
        end
      end
      S_ASSEMBLE: begin
        if (EN) begin
          shift_en = 1'b1;
          if (SOF) begin
            // Restart: this bit becomes bit 0 of a fresh word.
            frame_abort = 1'b1;
            shift_clr   = 1'b1;
            count_next  = CNT_W'(1);
          end else if (count_reg == LAST_BIT) begin
            word_done  = 1'b1;
            count_next = '0;
            state_next = S_IDLE;
          end else begin
            count_next = count_reg + CNT_W'(1);
          end
        end
      end
      default: begin
        state_next = S_IDLE;
        count_next = '0;
      end
    endcase
  end

  // FSM state and bit counter registers.
  always_ff @(posedge CLK or negedge n_Reset) begin
    if (!n_Reset) begin
      state_reg <= S_IDLE;
      count_reg <= '0;
    end else begin
      state_reg <= state_next;
      count_reg <= count_next;
    end
  end

  // Output holding register with valid/ready handshake.
  always_ff @(posedge CLK or negedge n_Reset) begin
    if (!n_Reset) begin
      datar_reg <= '0;
      valid_reg <= 1'b0;
    end else begin
      if (word_done && hold_free) begin
        datar_reg <= shift_next;
        valid_reg <= 1'b1;
      end else if (valid_reg && READY) begin
        valid_reg <= 1'b0;
      end
    end
  end

  // Sticky error flags; a set condition beats CLR_ERR on the same edge.
  always_ff @(posedge CLK or negedge n_Reset) begin
    if (!n_Reset) begin
      overrun_reg   <= 1'b0;
      frame_err_reg <= 1'b0;
    end else begin
      if (word_done && !hold_free) begin
        overrun_reg <= 1'b1;
      end else if (CLR_ERR) begin
        overrun_reg <= 1'b0;
      end
      if (frame_abort) begin
        frame_err_reg <= 1'b1;
      end else if (CLR_ERR) begin
        frame_err_reg <= 1'b0;
      end
    end
  end

  assign DATAR     = datar_reg;
  assign VALID     = valid_reg;
  assign OVERRUN   = overrun_reg;
  assign FRAME_ERR = frame_err_reg;

endmodule

// File: doc/serial_to_parallel_rx.md
# serial_to_parallel_rx

Deserialiser that consumes the single-bit LSB-first stream produced by the team's parallel-to-serial stage and rebuilds N-bit words. A start-of-frame qualifier marks bit 0 of each word and a bit counter tracks the frame. Completed words land in an output holding register with a valid/ready handshake, so a slow consumer is isolated from the serial link. Overrun and framing faults raise sticky flags.

## Interface
- N, 4, word width in bits; N >= 2.
- CLK  in  1  rising-edge clock.
- n_Reset  in  1  asynchronous, active-low reset.
- EN  in  1  bit strobe; SERIAL_IN/SOF sampled only on cycles with EN=1.
- SERIAL_IN  in  1  serial data, LSB first.
- SOF  in  1  qualifies the sampled bit as bit 0 of a new word.
- READY  in  1  consumer accepts DATAR when VALID=1.
- CLR_ERR  in  1  synchronous clear of OVERRUN and FRAME_ERR.
- DATAR  out  N  assembled word; bit k = k-th received bit.
- VALID  out  1  DATAR holds an unconsumed word.
- OVERRUN  out  1  sticky: a completed word was dropped.
- FRAME_ERR  out  1  sticky: a partial word was aborted by SOF.

## Operation
- States: S_IDLE (waiting for SOF), S_ASSEMBLE (bits 1..N-1 outstanding).
- S_IDLE: EN=1, SOF=0 -> bit ignored, stay. EN=1, SOF=1 -> capture bit 0, count=1, go to S_ASSEMBLE.
- S_ASSEMBLE, EN=1, SOF=0 -> shift bit in, count+1. When the bit just taken is bit N-1: word complete, count=0, go to S_IDLE.
- S_ASSEMBLE, EN=1, SOF=1 -> discard partial word, set FRAME_ERR, take this bit as the new bit 0, count=1, stay in S_ASSEMBLE.
- EN=0 in either state -> no change to the shift register, count or state (stall).
- Shift register shifts right with the new bit entering at the MSB. After N shifts, bit 0 sits at index 0.
- On word complete, the holding register is free if VALID=0 or (VALID=1 and READY=1) in the same cycle:
  - free -> load DATAR, VALID=1;
  - not free -> drop the new word, keep DATAR, set OVERRUN.
- Handshake: a transfer occurs on any edge with VALID=1 and READY=1. After it, VALID=0 unless a new word loads on the same edge. DATAR is stable while VALID=1 and READY=0.
- CLR_ERR=1 clears both sticky flags. If a set condition occurs on the same edge, the set wins.
- Count width is $clog2(N). Count never exceeds N-1.

## Timing
- Reset (async assert, sync-safe deassert): state=S_IDLE, count=0, shift register=0, DATAR=0, VALID=0, OVERRUN=0, FRAME_ERR=0.
- Latency: DATAR/VALID update on the same edge that samples bit N-1. They are visible in the following cycle.
- Minimum word period is N EN-cycles. Back-to-back words are supported: SOF on the EN cycle right after bit N-1 starts the next word with no gap.
- Reset mid-frame: the partial word is lost, no flag is set, and the link waits for SOF.
- Fully pipelined output: with READY held at 1, VALID pulses for exactly one cycle per word.

## Structure
- Shared package serdes_pkg:
  - state_t enum {S_IDLE, S_ASSEMBLE};
  - default width constant SERDES_N = 4, shared with the parallel-to-serial stage.
- One sub-module, sipo_shift_reg: N-bit right-shift register with an enable and a clear.
- FSM, counter, holding register and flags live in the top module.

## Test plan
- Reset then N=4, EN=1, bits 1,0,1,0 with SOF on the first bit, READY=1 -> DATAR=4'h5, VALID high for one cycle after the 4th bit edge, flags 0.
- Bits 1,1,1,1 with EN toggling 1,0,1,0,… -> DATAR=4'hF after 4 enabled cycles. The idle cycles do not shift.
- READY=0, two back-to-back frames 4'h3 then 4'hC -> DATAR stays 4'h3, VALID=1, OVERRUN=1. CLR_ERR -> OVERRUN=0.
- Frame 4'h9 with READY rising in the cycle its successor 4'h6 completes -> 4'h9 is consumed and 4'h6 loads on the same edge, VALID stays 1, no OVERRUN.
- SOF after 2 bits, then 4 bits 0,1,1,0 -> FRAME_ERR=1, DATAR=4'h6.
- n_Reset asserted after 2 bits of a frame -> all outputs 0 immediately. A following full frame 4'hA is received correctly.
